// File: rtl/cmp_seq.sv
// cmp_seq - multi-cycle, multi-mode operand comparator for branch resolution.
//
// Compares two WIDTH-bit operands CHUNK bits per cycle, most significant
// slice first, and stops at the first slice that differs. One unit covers
// the whole branch family (beq/bne/blt/bge/bltu/bgeu/blez/bgtz).
//
// Parameters:
//   WIDTH  operand width in bits (multiple of CHUNK)
//   CHUNK  bits compared per cycle (>= 1)
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   start   request, only sampled in IDLE or DONE
//   mode    0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 LEZ, 7 GTZ
//   a, b    operands (b is forced to zero for modes 6 and 7)
//   busy    high while slices are being scanned
//   done    one-cycle pulse, result/eq/lt valid
//   result  outcome of the selected mode, held until overwritten
//   eq      a == b, held with result
//   lt      a < b (signed or unsigned by mode), held with result
module cmp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]    IDX_TOP  = IW'(N - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("cmp_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Modes whose ordering is two's-complement signed.
  function automatic logic is_signed_mode(input logic [2:0] m);
    return (m == 3'd2) || (m == 3'd3) || (m == 3'd6) || (m == 3'd7);
  endfunction

  // Map the (eq, lt) pair onto the branch outcome for a mode.
  function automatic logic mode_outcome(input logic [2:0] m, input logic e, input logic l);
    logic r;
    case (m)
      3'd0:    r = e;
      3'd1:    r = ~e;
      3'd2:    r = l;
      3'd3:    r = ~l;
      3'd4:    r = l;
      3'd5:    r = ~l;
      3'd6:    r = l | e;
      3'd7:    r = ~(l | e);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state, state_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic [WIDTH-1:0] a_sh, a_sh_nx;
  logic [WIDTH-1:0] b_sh, b_sh_nx;
  logic [2:0]       mode_q, mode_nx;
  logic             busy_nx, done_nx, result_nx, eq_nx, lt_nx;

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic             slice_diff;
  logic             slice_lt;
  logic             last_slice;
  logic             accept;

  // The latched operands are shifted left each cycle, so the slice under
  // test is always the top CHUNK bits. Inverting the sign bit of the top
  // slice turns a signed comparison into an unsigned one.
  assign flip       = (is_signed_mode(mode_q) && (idx == IDX_TOP)) ? MSB_MASK : {CHUNK{1'b0}};
  assign a_slice    = a_sh[WIDTH-1 -: CHUNK] ^ flip;
  assign b_slice    = b_sh[WIDTH-1 -: CHUNK] ^ flip;
  assign slice_diff = (a_slice != b_slice);
  assign slice_lt   = (a_slice < b_slice);
  assign last_slice = (idx == {IW{1'b0}});
  assign accept     = start && ((state == IDLE) || (state == DONE));

  // State and datapath registers, including all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= IDX_TOP;
      a_sh   <= {WIDTH{1'b0}};
      b_sh   <= {WIDTH{1'b0}};
      mode_q <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      a_sh   <= a_sh_nx;
      b_sh   <= b_sh_nx;
      mode_q <= mode_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      result <= result_nx;
      eq     <= eq_nx;
      lt     <= lt_nx;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: begin
        if (start) state_nx = SCAN;
        else       state_nx = IDLE;
      end
      SCAN: begin
        if (slice_diff || last_slice) state_nx = DONE;
        else                          state_nx = SCAN;
      end
      DONE: begin
        if (start) state_nx = SCAN;
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the datapath and of the registered outputs.
  always_comb begin
    idx_nx    = idx;
    a_sh_nx   = a_sh;
    b_sh_nx   = b_sh;
    mode_nx   = mode_q;
    result_nx = result;
    eq_nx     = eq;
    lt_nx     = lt;
    busy_nx   = (state_nx == SCAN);
    done_nx   = (state_nx == DONE);

    if (accept) begin
      a_sh_nx = a;
      // Compare-against-zero modes ignore b entirely.
      if (mode[2:1] == 2'b11) b_sh_nx = {WIDTH{1'b0}};
      else                    b_sh_nx = b;
      mode_nx = mode;
      idx_nx  = IDX_TOP;
    end else if (state == SCAN) begin
      if (slice_diff) begin
        eq_nx     = 1'b0;
        lt_nx     = slice_lt;
        result_nx = mode_outcome(mode_q, 1'b0, slice_lt);
      end else if (last_slice) begin
        eq_nx     = 1'b1;
        lt_nx     = 1'b0;
        result_nx = mode_outcome(mode_q, 1'b1, 1'b0);
      end else begin
        a_sh_nx = a_sh << CHUNK;
        b_sh_nx = b_sh << CHUNK;
        idx_nx  = idx - IW'(1);
      end
    end else begin
      idx_nx = idx;
    end
  end

endmodule
